n1_sbus_mst: RTL
================

// Module: n1_sbus_mst
// PURPOSE
//  Stack bus Wishbone (pipelined) master for N1; sits directly downstream of the stack bus AGU.
//  Takes one cell access per request from the PRS, addresses it with the AGU's address and tags,
//  and runs it on the stack bus. Returns read data to the PRS and reports bus errors to EXCPT.
//  One outstanding transaction at a time.
// PARAMETERS
//  SP_WIDTH    12  width of stack bus address (= stack pointer width)
//  CELL_WIDTH  16  width of one stack cell (data bus width)
//  TMO_WIDTH    8  timeout counter width (only used with SBUS_TIMEOUT_EN)
// PORTS
//  clk_i                 in   1           system clock
//  async_rst_n_i         in   1           asynchronous reset, active-low
//  sbus_cyc_o            out  1           WB cycle
//  sbus_stb_o            out  1           WB strobe
//  sbus_we_o             out  1           WB write enable
//  sbus_adr_o            out  SP_WIDTH    WB address
//  sbus_tga_ps_o         out  1           tag: parameter stack access
//  sbus_tga_rs_o         out  1           tag: return stack access
//  sbus_dat_o            out  CELL_WIDTH  WB write data
//  sbus_ack_i            in   1           WB acknowledge
//  sbus_stall_i          in   1           WB stall
//  sbus_err_i            in   1           WB error
//  sbus_dat_i            in   CELL_WIDTH  WB read data
//  sagu2sbus_adr_i       in   SP_WIDTH    access address from AGU
//  sagu2sbus_tga_ps_i    in   1           PS tag from AGU
//  sagu2sbus_tga_rs_i    in   1           RS tag from AGU
//  prs2sbus_req_i        in   1           access request (held until accepted)
//  prs2sbus_we_i         in   1           1:write (push), 0:read (pull)
//  prs2sbus_dat_i        in   CELL_WIDTH  write data
//  sbus2prs_busy_o       out  1           transaction in progress, request not accepted
//  sbus2prs_done_o       out  1           one-cycle pulse: transaction finished (ack, err or timeout)
//  sbus2prs_dat_o        out  CELL_WIDTH  registered read data, valid with done pulse of a read
//  sbus2excpt_buserr_o   out  1           one-cycle pulse: bus error
//  sbus2excpt_tmo_o      out  1           one-cycle pulse: bus timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (cyc, stb, we, adr, tags, dat_o, busy, done, dat, buserr, tmo).
//  - All outputs registered. FSM states IDLE, REQ, WAIT; busy_o = (state != IDLE).
//  - IDLE & req_i: capture adr/tags/we/dat_o; next cycle cyc=stb=1, state REQ. No request in
//    IDLE -> hold.
//  - REQ: stb held with stable adr/dat until stall_i=0; then stb=0, state WAIT (cyc stays 1).
//    ack/err sampled while stall_i=0 in REQ completes immediately (zero-wait slave).
//  - WAIT: ack_i -> cyc=0, IDLE, done pulse, for reads dat_o of PRS <= sbus_dat_i.
//  - err_i (REQ with stall_i=0, or WAIT) -> cyc=0, IDLE, done + buserr pulse; read data unchanged.
//  - ack_i and err_i together: err wins. ack/err while cyc=0 or in REQ with stall_i=1: ignored.
//  - Min latency req->done: 3 cycles (accept, stb, ack). One idle cycle between transactions;
//    req_i seen while busy is ignored (PRS holds it).
//  - sbus2prs_dat_o holds the last read value until the next successful read.
//  - Async reset mid-transaction: cyc/stb drop immediately; no done pulse.
// CONFIGURATION
//  SBUS_TIMEOUT_EN defined: counter loaded with all-ones on entry to REQ, decrements each cycle in
//   REQ/WAIT; at 0 without ack/err -> cyc=stb=0, IDLE, done + tmo pulse (buserr stays 0).
//   ack/err in the cycle the counter reaches 0 takes priority over timeout.
//  Undefined: no counter, master waits indefinitely; sbus2excpt_tmo_o tied 0.
// TESTING
//  1 Reset: rst_n=0 during active cycle -> cyc=stb=busy=done=0 at once, dat_o=0.
//  2 Write: req, we=1, adr=0x123, tga_ps=1, dat=0xBEEF, no stall, ack next -> cyc/stb/we=1,
//    adr=0x123 one cycle, done pulse 3rd cycle.
//  3 Read with stall=1 for 2 cycles, ack 1 cycle after -> stb held 3 cycles, adr stable;
//    done with sbus2prs_dat_o=0x5A5A.
//  4 Error: ack=1, err=1 same cycle on read -> done + buserr pulse, sbus2prs_dat_o unchanged.
//  5 Back-to-back: req held 2 transactions -> second stb exactly 1 idle cycle after first done.
//  6 SBUS_TIMEOUT_EN, TMO_WIDTH=4, no ack -> tmo + done after 15 REQ/WAIT cycles, cyc=0;
//    without macro: busy stays 1.

Source files
------------

// File: rtl/n1_sbus_mst.sv
// Stack bus pipelined Wishbone master for N1: one cell access per PRS request, one outstanding transaction.
// Optional bus timeout watchdog enabled by defining SBUS_TIMEOUT_EN.
module n1_sbus_mst #(
  parameter int SP_WIDTH   = 12,
  parameter int CELL_WIDTH = 16,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  async_rst_n_i,
  output logic                  sbus_cyc_o,
  output logic                  sbus_stb_o,
  output logic                  sbus_we_o,
  output logic [SP_WIDTH-1:0]   sbus_adr_o,
  output logic                  sbus_tga_ps_o,
  output logic                  sbus_tga_rs_o,
  output logic [CELL_WIDTH-1:0] sbus_dat_o,
  input  logic                  sbus_ack_i,
  input  logic                  sbus_stall_i,
  input  logic                  sbus_err_i,
  input  logic [CELL_WIDTH-1:0] sbus_dat_i,
  input  logic [SP_WIDTH-1:0]   sagu2sbus_adr_i,
  input  logic                  sagu2sbus_tga_ps_i,
  input  logic                  sagu2sbus_tga_rs_i,
  input  logic                  prs2sbus_req_i,
  input  logic                  prs2sbus_we_i,
  input  logic [CELL_WIDTH-1:0] prs2sbus_dat_i,
  output logic                  sbus2prs_busy_o,
  output logic                  sbus2prs_done_o,
  output logic [CELL_WIDTH-1:0] sbus2prs_dat_o,
  output logic                  sbus2excpt_buserr_o,
  output logic                  sbus2excpt_tmo_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [SP_WIDTH-1:0]   adr_q, adr_d;
  logic                  ps_q, ps_d;
  logic                  rs_q, rs_d;
  logic [CELL_WIDTH-1:0] wdat_q, wdat_d;
  logic [CELL_WIDTH-1:0] rdat_q, rdat_d;
  logic                  done_q, done_d;
  logic                  buserr_q, buserr_d;
  logic                  resp_ok;
  logic                  fin;

`ifdef SBUS_TIMEOUT_EN
  logic [TMO_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  tmo_q, tmo_d;
`endif

  // Slave responses only count once the strobe has been taken (or is being taken this cycle).
  assign resp_ok = (state_q == WAIT) || ((state_q == REQ) && !sbus_stall_i);

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    ps_d     = ps_q;
    rs_d     = rs_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    done_d   = 1'b0;
    buserr_d = 1'b0;
    fin      = 1'b0;
`ifdef SBUS_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (prs2sbus_req_i) begin
          adr_d   = sagu2sbus_adr_i;
          ps_d    = sagu2sbus_tga_ps_i;
          rs_d    = sagu2sbus_tga_rs_i;
          we_d    = prs2sbus_we_i;
          wdat_d  = prs2sbus_dat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = REQ;
`ifdef SBUS_TIMEOUT_EN
          cnt_d   = '1;
`endif
        end
      end
      REQ, WAIT: begin
`ifdef SBUS_TIMEOUT_EN
        cnt_d = cnt_q - 1'b1;
`endif
        if ((state_q == REQ) && !sbus_stall_i) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
        // Error outranks ack; both outrank an expiring timeout.
        if (resp_ok && sbus_err_i) begin
          fin      = 1'b1;
          buserr_d = 1'b1;
        end else if (resp_ok && sbus_ack_i) begin
          fin = 1'b1;
          if (!we_q) rdat_d = sbus_dat_i;
        end
`ifdef SBUS_TIMEOUT_EN
        else if (cnt_q == TMO_WIDTH'(1)) begin
          fin   = 1'b1;
          tmo_d = 1'b1;
        end
`endif
        if (fin) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      ps_q     <= 1'b0;
      rs_q     <= 1'b0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      done_q   <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      ps_q     <= ps_d;
      rs_q     <= rs_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      done_q   <= done_d;
      buserr_q <= buserr_d;
    end
  end

`ifdef SBUS_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign sbus2excpt_tmo_o = tmo_q;
`else
  // Without the watchdog the master waits on the slave indefinitely.
  assign sbus2excpt_tmo_o = 1'b0;
`endif

  assign sbus_cyc_o          = cyc_q;
  assign sbus_stb_o          = stb_q;
  assign sbus_we_o           = we_q;
  assign sbus_adr_o          = adr_q;
  assign sbus_tga_ps_o       = ps_q;
  assign sbus_tga_rs_o       = rs_q;
  assign sbus_dat_o          = wdat_q;
  assign sbus2prs_busy_o     = (state_q != IDLE);
  assign sbus2prs_done_o     = done_q;
  assign sbus2prs_dat_o      = rdat_q;
  assign sbus2excpt_buserr_o = buserr_q;

endmodule
